// File: rtl/window_gen_3x3_pkg.sv
// Shared parameters for the 3x3 window generator slice: pixel width and
// default frame geometry, plus the pixel type used by the top module.
`ifndef WINDOW_GEN_3X3_PARAMS
`define WINDOW_GEN_3X3_PARAMS
`define PIXEL_WIDTH 8
`define IMG_WIDTH 640
`define IMG_HEIGHT 480
`endif

package window_gen_3x3_pkg;
  localparam int PIXEL_W   = `PIXEL_WIDTH;
  localparam int TAP_DEPTH = 3;

  typedef logic [PIXEL_W-1:0] pixel_t;
endpackage

// File: rtl/window_gen_3x3_line_buffer.sv
// One image line of storage: synchronous write, asynchronous read at the same
// address. Contents are deliberately not reset.
module line_buffer #(
  parameter int DEPTH  = 640,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write the addressed entry on an accepted pixel; the read below still
  // returns the old entry during that cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/window_gen_3x3.sv
// Raster-stream 3x3 window generator: two chained line buffers feed three
// 3-deep tap rows; a window is emitted one cycle after each pixel whose
// neighbourhood lies entirely inside the frame.
module window_gen_3x3
  import window_gen_3x3_pkg::*;
#(
  parameter int IMG_WIDTH  = `IMG_WIDTH,
  parameter int IMG_HEIGHT = `IMG_HEIGHT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  input  logic [PIXEL_W-1:0] i_pixel,
  output logic               o_valid,
  output logic [PIXEL_W-1:0] o_p0,
  output logic [PIXEL_W-1:0] o_p1,
  output logic [PIXEL_W-1:0] o_p2,
  output logic [PIXEL_W-1:0] o_p3,
  output logic [PIXEL_W-1:0] o_p4,
  output logic [PIXEL_W-1:0] o_p5,
  output logic [PIXEL_W-1:0] o_p6,
  output logic [PIXEL_W-1:0] o_p7,
  output logic [PIXEL_W-1:0] o_p8,
  output logic               o_last
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             col_end;
  logic             row_end;
  logic             win_ok;
  logic             lb_we;

  pixel_t lb0_rd;
  pixel_t lb1_rd;

  pixel_t top_tap  [TAP_DEPTH];
  pixel_t mid_tap  [TAP_DEPTH];
  pixel_t bot_tap  [TAP_DEPTH];
  pixel_t top_next [TAP_DEPTH];
  pixel_t mid_next [TAP_DEPTH];
  pixel_t bot_next [TAP_DEPTH];

  assign col_end = (col == COL_W'(IMG_WIDTH - 1));
  assign row_end = (row == ROW_W'(IMG_HEIGHT - 1));
  assign win_ok  = (row >= ROW_W'(2)) && (col >= COL_W'(2));

  // A pixel dropped by reset must not disturb the line buffers either.
  assign lb_we = i_valid && !rst;

  line_buffer #(
    .DEPTH  (IMG_WIDTH),
    .DATA_W (PIXEL_W)
  ) u_lb0 (
    .clk   (clk),
    .we    (lb_we),
    .addr  (col),
    .wdata (i_pixel),
    .rdata (lb0_rd)
  );

  line_buffer #(
    .DEPTH  (IMG_WIDTH),
    .DATA_W (PIXEL_W)
  ) u_lb1 (
    .clk   (clk),
    .we    (lb_we),
    .addr  (col),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  // Raster position of the next pixel to accept; wraps line and frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (i_valid) begin
      if (col_end) begin
        col <= '0;
        if (row_end) begin
          row <= '0;
        end else begin
          row <= row + ROW_W'(1);
        end
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Tap rows after a left shift: index 0 is the oldest column, the newest
  // column enters from the line-buffer reads and the incoming pixel.
  always_comb begin
    for (int i = 0; i < TAP_DEPTH - 1; i++) begin
      top_next[i] = top_tap[i+1];
      mid_next[i] = mid_tap[i+1];
      bot_next[i] = bot_tap[i+1];
    end
    top_next[TAP_DEPTH-1] = lb1_rd;
    mid_next[TAP_DEPTH-1] = lb0_rd;
    bot_next[TAP_DEPTH-1] = i_pixel;
  end

  // Tap registers advance only on accepted pixels, across line boundaries too.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAP_DEPTH; i++) begin
        top_tap[i] <= '0;
        mid_tap[i] <= '0;
        bot_tap[i] <= '0;
      end
    end else if (i_valid) begin
      for (int i = 0; i < TAP_DEPTH; i++) begin
        top_tap[i] <= top_next[i];
        mid_tap[i] <= mid_next[i];
        bot_tap[i] <= bot_next[i];
      end
    end
  end

  // Register the window one cycle after a completing pixel; pixels hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_p0    <= '0;
      o_p1    <= '0;
      o_p2    <= '0;
      o_p3    <= '0;
      o_p4    <= '0;
      o_p5    <= '0;
      o_p6    <= '0;
      o_p7    <= '0;
      o_p8    <= '0;
    end else begin
      o_valid <= i_valid && win_ok;
      o_last  <= i_valid && win_ok && row_end && col_end;
      if (i_valid && win_ok) begin
        o_p0 <= top_next[0];
        o_p1 <= top_next[1];
        o_p2 <= top_next[2];
        o_p3 <= mid_next[0];
        o_p4 <= mid_next[1];
        o_p5 <= mid_next[2];
        o_p6 <= bot_next[0];
        o_p7 <= bot_next[1];
        o_p8 <= bot_next[2];
      end
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3 on a 5x4 frame with pixel = 10*row+col
// (plus a per-frame offset). A frame-store model predicts every output cycle;
// literal windows pin the model.
module tb_window_gen_3x3;
  import window_gen_3x3_pkg::*;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int PW = PIXEL_W;

  logic          clk;
  logic          rst;
  logic          i_valid;
  logic [PW-1:0] i_pixel;
  logic          o_valid;
  logic          o_last;
  logic [PW-1:0] o_p0, o_p1, o_p2, o_p3, o_p4, o_p5, o_p6, o_p7, o_p8;
  logic [PW-1:0] dut_p [9];

  int n_cmp = 0;
  int n_err = 0;
  int win_count = 0;
  int last_count = 0;
  logic check_en = 1'b0;

  window_gen_3x3 #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_pixel (i_pixel),
    .o_valid (o_valid),
    .o_p0    (o_p0),
    .o_p1    (o_p1),
    .o_p2    (o_p2),
    .o_p3    (o_p3),
    .o_p4    (o_p4),
    .o_p5    (o_p5),
    .o_p6    (o_p6),
    .o_p7    (o_p7),
    .o_p8    (o_p8),
    .o_last  (o_last)
  );

  assign dut_p[0] = o_p0;
  assign dut_p[1] = o_p1;
  assign dut_p[2] = o_p2;
  assign dut_p[3] = o_p3;
  assign dut_p[4] = o_p4;
  assign dut_p[5] = o_p5;
  assign dut_p[6] = o_p6;
  assign dut_p[7] = o_p7;
  assign dut_p[8] = o_p8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a frame store indexed by raster position; the window is read
  // straight out of the stored image.
  int            m_row = 0;
  int            m_col = 0;
  int            img [H][W];
  logic          m_valid = 1'b0;
  logic          m_last = 1'b0;
  logic [PW-1:0] m_p [9];

  always @(posedge clk) begin
    if (rst) begin
      m_row = 0;
      m_col = 0;
      m_valid = 1'b0;
      m_last = 1'b0;
      for (int k = 0; k < 9; k++) m_p[k] = '0;
    end else if (i_valid) begin
      img[m_row][m_col] = int'(i_pixel);
      if (m_row >= 2 && m_col >= 2) begin
        m_valid = 1'b1;
        m_last = (m_row == H - 1) && (m_col == W - 1);
        for (int k = 0; k < 9; k++)
          m_p[k] = PW'(img[m_row - 2 + k / 3][m_col - 2 + k % 3]);
      end else begin
        m_valid = 1'b0;
        m_last = 1'b0;
      end
      m_col = m_col + 1;
      if (m_col == W) begin
        m_col = 0;
        m_row = (m_row + 1) % H;
      end
    end else begin
      m_valid = 1'b0;
      m_last = 1'b0;
    end
  end

  // Every cycle, compare all DUT outputs with the model and tally window pulses.
  always @(negedge clk) begin
    if (check_en) begin
      logic bad;
      bad = (o_valid !== m_valid) || (o_last !== m_last);
      for (int k = 0; k < 9; k++) if (dut_p[k] !== m_p[k]) bad = 1'b1;
      n_cmp++;
      if (bad) begin
        n_err++;
        $display("[TB] FAIL model_cycle t=%0t got v=%0b l=%0b p=%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d required v=%0b l=%0b p=%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d",
                 $time, o_valid, o_last, o_p0, o_p1, o_p2, o_p3, o_p4, o_p5, o_p6, o_p7, o_p8,
                 m_valid, m_last, m_p[0], m_p[1], m_p[2], m_p[3], m_p[4], m_p[5], m_p[6], m_p[7], m_p[8]);
      end
      if (o_valid === 1'b1) win_count++;
      if (o_last === 1'b1) last_count++;
    end
  end

  task automatic applyStimulus(input logic v, input logic r, input logic [PW-1:0] pix);
    @(negedge clk);
    i_valid = v;
    rst = r;
    i_pixel = pix;
  endtask

  task automatic sendPixels(input int base, input int first, input int last, input bit gaps);
    for (int i = first; i <= last; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) applyStimulus(1'b0, 1'b0, PW'(8'hEE));
      applyStimulus(1'b1, 1'b0, PW'(base + 10 * (i / W) + (i % W)));
    end
  endtask

  // Check the outputs just after the next rising edge.
  task automatic checkOutput(input string name, input logic exp_v, input logic exp_l, input int exp_p [9]);
    logic bad;
    @(posedge clk);
    #1;
    bad = (o_valid !== exp_v) || (o_last !== exp_l);
    for (int k = 0; k < 9; k++) if (dut_p[k] !== PW'(exp_p[k])) bad = 1'b1;
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("[TB] FAIL %s got v=%0b l=%0b p=%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d required v=%0b l=%0b p=%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d",
               name, o_valid, o_last, o_p0, o_p1, o_p2, o_p3, o_p4, o_p5, o_p6, o_p7, o_p8,
               exp_v, exp_l, exp_p[0], exp_p[1], exp_p[2], exp_p[3], exp_p[4], exp_p[5], exp_p[6], exp_p[7], exp_p[8]);
    end
  endtask

  task automatic checkIdle(input string name);
    @(posedge clk);
    #1;
    n_cmp++;
    if (o_valid !== 1'b0 || o_last !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL %s got v=%0b l=%0b required v=0 l=0", name, o_valid, o_last);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("[TB] FAIL %s got %0d required %0d", name, got, want);
    end
  endtask

  int start_win;
  int start_last;

  initial begin
    rst = 1'b1;
    i_valid = 1'b0;
    i_pixel = '0;
    applyStimulus(1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("reset_state", 1'b0, 1'b0, '{0, 0, 0, 0, 0, 0, 0, 0, 0});
    check_en = 1'b1;

    $display("[TB] continuous frame then back-to-back frame +100");
    start_win = win_count;
    start_last = last_count;
    sendPixels(0, 0, 10, 1'b0);
    checkIdle("no_win_p20");
    sendPixels(0, 11, 11, 1'b0);
    checkIdle("no_win_p21");
    sendPixels(0, 12, 12, 1'b0);
    checkOutput("first_window", 1'b1, 1'b0, '{0, 1, 2, 10, 11, 12, 20, 21, 22});
    sendPixels(0, 13, 15, 1'b0);
    checkIdle("no_win_p30");
    sendPixels(0, 16, 16, 1'b0);
    checkIdle("no_win_p31");
    sendPixels(0, 17, 17, 1'b0);
    checkOutput("window_p32", 1'b1, 1'b0, '{10, 11, 12, 20, 21, 22, 30, 31, 32});
    sendPixels(0, 18, 19, 1'b0);
    checkOutput("last_window", 1'b1, 1'b1, '{12, 13, 14, 22, 23, 24, 32, 33, 34});
    sendPixels(100, 0, 12, 1'b0);
    checkOutput("frame2_first", 1'b1, 1'b0, '{100, 101, 102, 110, 111, 112, 120, 121, 122});
    sendPixels(100, 13, 19, 1'b0);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    checkCount("two_frame_windows", win_count - start_win, 12);
    checkCount("two_frame_lasts", last_count - start_last, 2);

    $display("[TB] frame with random i_valid gaps");
    start_win = win_count;
    start_last = last_count;
    sendPixels(0, 0, 19, 1'b1);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    checkCount("gap_frame_windows", win_count - start_win, 6);
    checkCount("gap_frame_lasts", last_count - start_last, 1);

    $display("[TB] mid-frame reset with i_valid high during reset");
    sendPixels(0, 0, 13, 1'b0);
    checkOutput("window_p23", 1'b1, 1'b0, '{1, 2, 3, 11, 12, 13, 21, 22, 23});
    applyStimulus(1'b1, 1'b1, PW'(99));
    checkOutput("reset_clears", 1'b0, 1'b0, '{0, 0, 0, 0, 0, 0, 0, 0, 0});
    applyStimulus(1'b1, 1'b1, PW'(98));
    checkOutput("reset_held", 1'b0, 1'b0, '{0, 0, 0, 0, 0, 0, 0, 0, 0});
    start_win = win_count;
    start_last = last_count;
    sendPixels(0, 0, 11, 1'b0);
    checkIdle("after_reset_no_win_p21");
    sendPixels(0, 12, 12, 1'b0);
    checkOutput("after_reset_first", 1'b1, 1'b0, '{0, 1, 2, 10, 11, 12, 20, 21, 22});
    sendPixels(0, 13, 19, 1'b0);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    checkCount("after_reset_windows", win_count - start_win, 6);
    checkCount("after_reset_lasts", last_count - start_last, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
